// File: rtl/tmr_serial_deframer.sv
// tmr_serial_deframer: rebuilds parallel words from start/stop framed serial data.
// FSM, counter, shift register and outputs are triplicated, voted and scrubbed each clock.
module tmr_serial_deframer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serial_in,
  input  logic [2:0]       inj_mask,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             frame_error,
  output logic             tmr_error,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_e;
  logic [1:0]       st_q  [3];
  logic [CW-1:0]    cnt_q [3];
  logic [WIDTH-1:0] sh_q  [3];
  logic [WIDTH-1:0] wo_q  [3];
  logic             wv_q  [3];
  logic             fe_q  [3];
  logic             te_q  [3];
  logic [1:0]       st_v;
  logic [CW-1:0]    cnt_v, cnt_d;
  logic [WIDTH-1:0] sh_v, sh_d, wo_d;
  logic             wv_d, fe_d, mis;
  state_e           st, st_d;
  assign st_v  = (st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]);
  assign cnt_v = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
  assign sh_v  = (sh_q[0] & sh_q[1]) | (sh_q[0] & sh_q[2]) | (sh_q[1] & sh_q[2]);
  assign st    = state_e'(st_v);
  assign word_out    = (wo_q[0] & wo_q[1]) | (wo_q[0] & wo_q[2]) | (wo_q[1] & wo_q[2]);
  assign word_valid  = (wv_q[0] & wv_q[1]) | (wv_q[0] & wv_q[2]) | (wv_q[1] & wv_q[2]);
  assign frame_error = (fe_q[0] & fe_q[1]) | (fe_q[0] & fe_q[2]) | (fe_q[1] & fe_q[2]);
  assign tmr_error   = (te_q[0] & te_q[1]) | (te_q[0] & te_q[2]) | (te_q[1] & te_q[2]);
  assign busy        = st != IDLE;
  // Any replica out of line with the others this cycle flags tmr_error at the next edge.
  assign mis = (st_q[0] != st_q[1]) || (st_q[0] != st_q[2]) ||
               (cnt_q[0] != cnt_q[1]) || (cnt_q[0] != cnt_q[2]) ||
               (sh_q[0] != sh_q[1]) || (sh_q[0] != sh_q[2]) ||
               (wo_q[0] != wo_q[1]) || (wo_q[0] != wo_q[2]) ||
               (wv_q[0] != wv_q[1]) || (wv_q[0] != wv_q[2]) ||
               (fe_q[0] != fe_q[1]) || (fe_q[0] != fe_q[2]);
  always_comb begin
    st_d  = st;
    cnt_d = cnt_v;
    sh_d  = sh_v;
    wo_d  = word_out;
    wv_d  = 1'b0;
    fe_d  = 1'b0;
    case (st)
      IDLE: if (enable && serial_in) begin
        st_d  = DATA;
        cnt_d = '0;
      end
      DATA: if (enable) begin
        sh_d  = {sh_v[WIDTH-2:0], serial_in};
        cnt_d = cnt_v + CW'(1);
        st_d  = (cnt_v == CW'(WIDTH - 1)) ? STOP : DATA;
      end
      STOP: if (enable) begin
        st_d = IDLE;
        wo_d = serial_in ? word_out : sh_v;
        wv_d = !serial_in;
        fe_d = serial_in;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        st_q[r]  <= IDLE;
        cnt_q[r] <= '0;
        sh_q[r]  <= '0;
        wo_q[r]  <= '0;
        wv_q[r]  <= 1'b0;
        fe_q[r]  <= 1'b0;
        te_q[r]  <= 1'b0;
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        st_q[r]  <= st_d;
        cnt_q[r] <= cnt_d;
        sh_q[r]  <= sh_d ^ WIDTH'(inj_mask[r]);
        wo_q[r]  <= wo_d;
        wv_q[r]  <= wv_d;
        fe_q[r]  <= fe_d;
        te_q[r]  <= mis;
      end
    end
endmodule

// File: tb/tb_tmr_serial_deframer.sv
// tb_tmr_serial_deframer: directed frames with a scoreboard of expected words.
module tb_tmr_serial_deframer;
  localparam int WIDTH = 4;
  logic             clk = 1'b0;
  logic             rst, enable, serial_in;
  logic [2:0]       inj_mask;
  logic [WIDTH-1:0] word_out;
  logic             word_valid, frame_error, tmr_error, busy;
  int               n_assert = 0, n_fail = 0;
  int               wv_cnt, fe_cnt, te_cnt, busy_cnt;
  logic [WIDTH-1:0] sb [$];

  always #5 clk = ~clk;

  tmr_serial_deframer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in), .inj_mask(inj_mask),
    .word_out(word_out), .word_valid(word_valid), .frame_error(frame_error),
    .tmr_error(tmr_error), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wv_cnt = 0;
    fe_cnt = 0;
    te_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic step(input logic en, input logic si, input logic [2:0] inj);
    enable = en;
    serial_in = si;
    inj_mask = inj;
    @(posedge clk);
    #1;
    inj_mask = 3'b000;
    busy_cnt += int'(busy);
    te_cnt += int'(tmr_error);
    fe_cnt += int'(frame_error);
    if (word_valid) begin
      wv_cnt++;
      if (sb.size() == 0) chk("unexpected_word_valid", 32'(word_valid), 32'd0);
      else chk("word_out", 32'(word_out), 32'(sb.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 3'b000);
  endtask

  // f is sent MSB first: start, WIDTH data bits, stop
  task automatic frame(input logic [5:0] f, input int inj_edge, input logic [2:0] inj,
                       input logic [WIDTH-1:0] exp);
    if (!f[0]) sb.push_back(exp);
    for (int i = 0; i < 6; i++) step(1'b1, f[5-i], (i == inj_edge) ? inj : 3'b000);
    chk("word_valid_latency", 32'(word_valid), 32'(!f[0]));
    chk("frame_error_latency", 32'(frame_error), 32'(f[0]));
  endtask

  task automatic tally(input string t, input int wv, input int fe, input int te,
                       input logic [WIDTH-1:0] w);
    chk({t, "_word_valid_pulses"}, 32'(wv_cnt), 32'(wv));
    chk({t, "_frame_error_pulses"}, 32'(fe_cnt), 32'(fe));
    chk({t, "_tmr_error_pulses"}, 32'(te_cnt), 32'(te));
    chk({t, "_word_out_final"}, 32'(word_out), 32'(w));
    chk({t, "_scoreboard_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_assert=%0d", n_assert);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    serial_in = 1'b0;
    inj_mask = 3'b000;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_word_out", 32'(word_out), 32'd0);
    chk("reset_word_valid", 32'(word_valid), 32'd0);
    chk("reset_frame_error", 32'(frame_error), 32'd0);
    chk("reset_tmr_error", 32'(tmr_error), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    // test 1: reset mid-frame, then a clean frame
    step(1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    chk("t1_busy_midframe", 32'(busy), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_word_out", 32'(word_out), 32'd0);
    chk("t1_async_word_valid", 32'(word_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr();
    frame(6'b101100, -1, 3'b000, 4'b0110);
    idle(3);
    tally("t1", 1, 0, 0, 4'b0110);
    // test 2: contiguous frame
    clr();
    frame(6'b110110, -1, 3'b000, 4'b1011);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd5);
    idle(3);
    tally("t2", 1, 0, 0, 4'b1011);
    // test 3: two-cycle enable gap after the 2nd data bit
    clr();
    sb.push_back(4'b1011);
    step(1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b000);
    chk("t3_busy_gap1", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 3'b000);
    chk("t3_busy_gap2", 32'(busy), 32'd1);
    step(1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    chk("t3_word_valid_latency", 32'(word_valid), 32'd1);
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd7);
    idle(3);
    tally("t3", 1, 0, 0, 4'b1011);
    // test 4: stop-bit error, then a back-to-back good frame
    clr();
    frame(6'b111101, -1, 3'b000, 4'b0000);
    chk("t4_word_out_held", 32'(word_out), 32'(4'b1011));
    frame(6'b100110, -1, 3'b000, 4'b0011);
    idle(3);
    tally("t4", 1, 1, 0, 4'b0011);
    // test 5: single-replica upset on the 2nd data bit is outvoted
    clr();
    frame(6'b110100, 2, 3'b010, 4'b1010);
    idle(3);
    tally("t5", 1, 0, 1, 4'b1010);
    // test 6: two-replica upset on the last data bit wins the vote
    clr();
    frame(6'b110100, 4, 3'b011, 4'b1011);
    idle(3);
    tally("t6", 1, 0, 1, 4'b1011);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tmr_serial_deframer.md
Name: tmr_serial_deframer

Overview:
- Receive-side counterpart of the TMR universal shift register: consumes the register's serial output and rebuilds parallel words.
- Detects start-bit framed serial words, deserializes WIDTH data bits MSB first, checks the stop bit, and presents the word in parallel.
- All state (FSM, bit counter, shift register, output registers) is triplicated, majority-voted and self-scrubbed every clock.
- Fault-injection inputs let benches exercise the voter.

Parameters:
WIDTH, 4, number of data bits per frame (2..16)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
enable  input  1  bit strobe; serial_in is sampled only on edges where enable=1
serial_in  input  1  serial line; idle level 0
inj_mask  input  3  fault injection; bit i set inverts replica i shift-register bit 0 at this edge
word_out  output  WIDTH  last correctly framed word (voted)
word_valid  output  1  one-cycle pulse: word_out updated
frame_error  output  1  one-cycle pulse: stop bit was 1
tmr_error  output  1  one-cycle pulse: replicas disagreed in previous cycle
busy  output  1  1 while FSM is not IDLE (voted)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst=0); it is asserted asynchronously and takes effect immediately.
- Reset values (all three replicas):
  - State IDLE, counter 0, shift register 0.
  - word_out=0, word_valid=0, frame_error=0, tmr_error=0, busy=0.
  - Reset mid-frame discards the partial word.
- Frame format: start bit 1, then WIDTH data bits MSB first, then stop bit 0. A frame is WIDTH+2 enabled cycles.
- enable=0 edges: state, counter, shift register and word_out hold; word_valid and frame_error go 0. Injection still applies.
- FSM is computed from voted state; the result is written to all three replicas:
  - IDLE: enable & serial_in=1 -> DATA, counter=0. serial_in=0 -> stay.
  - DATA: on enable, shreg={shreg[WIDTH-2:0],serial_in}, counter+1. When counter==WIDTH-1 on that edge -> STOP.
  - STOP, enable & serial_in=0: word_out<=voted shreg, word_valid=1 for one cycle -> IDLE.
  - STOP, enable & serial_in=1: frame_error=1 for one cycle, word_out unchanged -> IDLE. The 1 is not taken as a new start bit.
  - Illegal voted state encoding -> IDLE.
- Latency: word_valid/word_out are visible in the cycle after the edge that samples the stop bit.
- Back-to-back frames: a start bit on the enabled edge right after the stop edge is accepted.
- Voting:
  - Bitwise 2-of-3 majority on every replicated register; outputs are combinational votes of the output replicas.
  - Single-replica corruption never reaches outputs and is scrubbed at the next edge.
- Injection: at an edge, replica i stores its computed shift-register value with bit 0 inverted when inj_mask[i]=1. This applies in any state, independent of enable.
- tmr_error:
  - Registered; set at an edge if any voted field had a disagreeing replica during the preceding cycle, else cleared.
  - Injection at edge k -> tmr_error high for exactly the cycle after edge k+1.
  - A single-replica fault is scrubbed at edge k+1; a two-replica fault wins the vote.
- busy = voted state != IDLE.

Test Plan:
1. Reset: assert rst=0 after 2 data bits of a frame -> all outputs 0 immediately, busy=0. Release, send 1,0,1,1,0,0 -> word_out=4'b0110, word_valid one pulse.
2. Contiguous frame (enable=1): 1,1,0,1,1,0 -> word_out=4'b1011 one cycle after the 6th edge; busy high for 5 cycles; frame_error=0, tmr_error=0.
3. Enable gaps: same frame with enable=0 for 2 cycles after the 2nd data bit, serial_in toggling during the gap -> word_out=4'b1011, busy held through the gap.
4. Stop error then recovery: 1,1,1,1,0,1 -> frame_error one pulse, word_valid=0, word_out keeps 4'b1011. Immediately 1,0,0,1,1,0 -> word_out=4'b0011.
5. Single upset: inj_mask=3'b010 on the edge sampling the 2nd data bit of frame 1,1,0,1,0,0 -> word_out=4'b1010, tmr_error exactly one pulse.
6. Double upset: inj_mask=3'b011 on the edge sampling the last data bit of frame 1,1,0,1,0,0 -> word_out=4'b1011 (LSB corrupted by design), tmr_error one pulse.
